// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the I/O bus round-robin arbiter.
package io_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUS, HOLD} arb_state_e;
    localparam logic [11:0] IO_BASE_DEF = 12'hFFD;
    localparam int          CNT_W       = 16;
endpackage

// File: rtl/io_bus_arbiter_if.sv
// Multi-master request side plus the single shared I/O port.
interface io_bus_arbiter_if #(parameter int NMST = 4);
    logic [NMST-1:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [NMST-1:0][3:0]   m_sel_i;
    logic [NMST-1:0][31:0]  m_adr_i, m_dat_i;
    logic [NMST-1:0]        m_ack_o, m_err_o;
    logic [31:0]            m_dat_o;
    logic                   s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]             s_sel_o;
    logic [31:0]            s_adr_o, s_dat_o;
    logic                   s_ack_i;
    logic [31:0]            s_dat_i;

    // Arbiter side.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
    // Masters and device side.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module io_rr_pick #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);
    int j;

    // Scan farthest-to-nearest so the nearest requester is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = W'(j);
            end
        end
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one I/O bus port among NMST masters, with a
// per-cycle ack watchdog that turns a silent device into an error response.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter  int          NMST    = 4,
    parameter  int          TMO     = 255,
    parameter  logic [11:0] IO_BASE = IO_BASE_DEF,
    localparam int          GW      = $clog2(NMST)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    io_bus_arbiter_if.slave  bus,
    output logic [GW-1:0]    gnt_o,
    output logic [CNT_W-1:0] tmo_cnt_o
);
    arb_state_e       state, state_nxt;
    logic [NMST-1:0]  req;
    logic [GW-1:0]    ptr, pick_idx;
    logic             pick_vld;
    logic [CNT_W-1:0] wdog;
    logic             grant, take_ack, abort, tmo_hit, release_c;

    always_comb begin
        for (int i = 0; i < NMST; i++)
            req[i] = bus.m_cyc_i[i] & bus.m_stb_i[i] & (bus.m_adr_i[i][31:20] == IO_BASE);
    end

    io_rr_pick #(.N(NMST)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!bus.s_ack_i && pick_vld) state_nxt = BUS;
            BUS:     if (bus.s_ack_i)                    state_nxt = HOLD;
                     else if (!bus.m_cyc_i[gnt_o])       state_nxt = IDLE;
                     else if (wdog == CNT_W'(TMO))       state_nxt = HOLD;
            HOLD:    if (!bus.m_stb_i[gnt_o]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack beats both abort and timeout in the same cycle.
    always_comb begin
        grant     = (state == IDLE) && !bus.s_ack_i && pick_vld;
        take_ack  = (state == BUS) && bus.s_ack_i;
        abort     = (state == BUS) && !bus.s_ack_i && !bus.m_cyc_i[gnt_o];
        tmo_hit   = (state == BUS) && !bus.s_ack_i && bus.m_cyc_i[gnt_o] && (wdog == CNT_W'(TMO));
        release_c = (state == HOLD) && !bus.m_stb_i[gnt_o];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
            bus.s_we_o  <= 1'b0;
            bus.s_sel_o <= '0;
            bus.s_adr_o <= '0;
            bus.s_dat_o <= '0;
            bus.m_ack_o <= '0;
            bus.m_err_o <= '0;
            bus.m_dat_o <= '0;
            tmo_cnt_o   <= '0;
            gnt_o       <= '0;
            ptr         <= GW'(NMST - 1);
            wdog        <= '0;
        end else begin
            if (grant) begin
                gnt_o       <= pick_idx;
                bus.s_cyc_o <= 1'b1;
                bus.s_stb_o <= 1'b1;
                bus.s_we_o  <= bus.m_we_i[pick_idx];
                bus.s_sel_o <= bus.m_sel_i[pick_idx];
                bus.s_adr_o <= bus.m_adr_i[pick_idx];
                bus.s_dat_o <= bus.m_dat_i[pick_idx];
                wdog        <= '0;
            end
            if (take_ack || abort || tmo_hit) begin
                bus.s_cyc_o <= 1'b0;
                bus.s_stb_o <= 1'b0;
                bus.s_we_o  <= 1'b0;
            end
            if (take_ack) begin
                bus.m_dat_o        <= bus.s_dat_i;
                bus.m_ack_o[gnt_o] <= 1'b1;
            end
            if (tmo_hit) begin
                bus.m_err_o[gnt_o] <= 1'b1;
                if (tmo_cnt_o != '1) tmo_cnt_o <= tmo_cnt_o + 1'b1;
            end
            if ((state == BUS) && !take_ack && !abort && !tmo_hit) wdog <= wdog + 1'b1;
            // Pointer only moves once the winner has finished its handshake.
            if (release_c) begin
                bus.m_ack_o <= '0;
                bus.m_err_o <= '0;
                ptr         <= gnt_o;
            end
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: master engine, simple device model, queue of expected completions.
module tb_io_bus_arbiter;
    import io_arb_pkg::*;
    localparam int NMST = 4;
    localparam int TMO  = 15;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  gnt_o;
    logic [15:0] tmo_cnt_o;

    io_bus_arbiter_if #(.NMST(NMST)) bus();

    io_bus_arbiter #(.NMST(NMST), .TMO(TMO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus.slave),
        .gnt_o     (gnt_o),
        .tmo_cnt_o (tmo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [1:0] idx; logic err; logic [31:0] dat; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Device: acks ack_dly cycles after seeing s_cyc_o; ack_dly < 0 never acks.
    int          ack_dly = 0;
    int          dcnt    = 0;
    logic [31:0] dev_key = 32'h0;
    always @(posedge clk_i) begin
        if (rst_i || !bus.s_cyc_o || bus.s_ack_i) begin
            dcnt        <= 0;
            bus.s_ack_i <= 1'b0;
        end else if (ack_dly >= 0 && dcnt == ack_dly) begin
            bus.s_ack_i <= 1'b1;
            bus.s_dat_i <= dev_key ^ bus.s_adr_o;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    logic [31:0]     madr[NMST], mdat[NMST];
    logic [3:0]      msel[NMST];
    logic            mwe[NMST];
    int              pend[NMST];
    logic            auto_en = 1'b0;
    logic [NMST-1:0] prev_done = '0;
    logic            prev_cyc = 1'b0;
    int              cyc_n = 0, rise_cyc = 0, last_lat = 0;
    logic [NMST-1:0] last_ack, last_err;
    logic [31:0]     last_dat;

    task automatic setm(int i, logic [31:0] a, logic we, logic [3:0] sel, logic [31:0] d);
        madr[i] = a; mwe[i] = we; msel[i] = sel; mdat[i] = d;
    endtask

    task automatic raise(int i);
        bus.m_cyc_i[i] = 1'b1; bus.m_stb_i[i] = 1'b1; bus.m_we_i[i] = mwe[i];
        bus.m_sel_i[i] = msel[i]; bus.m_adr_i[i] = madr[i]; bus.m_dat_i[i] = mdat[i];
    endtask

    task automatic drop(int i);
        bus.m_cyc_i[i] = 1'b0; bus.m_stb_i[i] = 1'b0;
    endtask

    task automatic push(int i, logic e);
        sb.push_back('{idx: 2'(i), err: e, dat: dev_key ^ madr[i]});
    endtask

    // One cycle: observe at negedge, score completions, run the master engine.
    task automatic tick();
        logic [NMST-1:0] cur, done_v, dropped;
        exp_t e;
        @(negedge clk_i);
        cyc_n++;
        cur       = bus.m_ack_o | bus.m_err_o;
        done_v    = cur & ~prev_done;
        prev_done = cur;
        dropped   = '0;
        if (bus.s_cyc_o && !prev_cyc) rise_cyc = cyc_n;
        prev_cyc = bus.s_cyc_o;
        if (bus.s_cyc_o) begin
            chk("s_adr", bus.s_adr_o, madr[gnt_o]);
            chk("s_we",  32'(bus.s_we_o), 32'(mwe[gnt_o]));
            chk("s_sel", 32'(bus.s_sel_o), 32'(msel[gnt_o]));
            chk("s_dat", bus.s_dat_o, mdat[gnt_o]);
        end
        if (cur != '0) chk("resp_onehot", 32'($countones(cur)), 1);
        for (int i = 0; i < NMST; i++) begin
            if (done_v[i]) begin
                if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
                else begin
                    e = sb.pop_front();
                    chk("done_idx", i, 32'(e.idx));
                    chk("done_err", 32'(bus.m_err_o[i]), 32'(e.err));
                    if (!e.err) chk("done_rdata", bus.m_dat_o, e.dat);
                end
                chk("done_gnt", 32'(gnt_o), i);
                chk("done_scyc", 32'(bus.s_cyc_o), 0);
                last_lat = cyc_n - rise_cyc;
                last_ack = bus.m_ack_o; last_err = bus.m_err_o; last_dat = bus.m_dat_o;
                if (auto_en && pend[i] > 0) begin
                    drop(i); pend[i]--; dropped[i] = 1'b1;
                end
            end
        end
        if (auto_en)
            for (int i = 0; i < NMST; i++)
                if (pend[i] > 0 && !bus.m_cyc_i[i] && !dropped[i]) raise(i);
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin tick(); n++; end
        if (sb.size() != 0) begin
            chk("wait_budget", 32'(sb.size()), 0);
            sb.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: no summary after 200000 time units");
        $fatal(1);
    end

    initial begin
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_sel_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
        for (int i = 0; i < NMST; i++) begin pend[i] = 0; setm(i, 32'h0, 1'b0, 4'h0, 32'h0); end
        repeat (3) tick();
        chk("rst_scyc", 32'(bus.s_cyc_o), 0);
        chk("rst_gnt",  32'(gnt_o), 0);
        chk("rst_tmo",  32'(tmo_cnt_o), 0);
        chk("rst_resp", 32'(bus.m_ack_o | bus.m_err_o), 0);
        rst_i = 1'b0;
        auto_en = 1'b1;

        // Single read by master 2, device acks three cycles after s_cyc_o.
        ack_dly = 2;
        dev_key = 32'h1234_5678 ^ 32'hFFD0_0104;
        setm(2, 32'hFFD0_0104, 1'b0, 4'hF, 32'h0);
        sb.push_back('{idx: 2'd2, err: 1'b0, dat: 32'h1234_5678});
        pend[2] = 1;
        tick();
        tick();
        chk("rd_scyc", 32'(bus.s_cyc_o), 1);
        chk("rd_gnt",  32'(gnt_o), 2);
        wait_done(30);
        chk("rd_lat",    last_lat, 4);
        chk("rd_ackvec", 32'(last_ack), 32'b0100);
        chk("rd_data",   last_dat, 32'h1234_5678);

        // Timeout: device never answers.
        ack_dly = -1;
        dev_key = 32'hCAFE_0000;
        setm(1, 32'hFFD0_0200, 1'b1, 4'h3, 32'hDEAD_BEEF);
        push(1, 1'b1);
        pend[1] = 1;
        wait_done(60);
        chk("tmo_lat",    last_lat, TMO + 1);
        chk("tmo_errvec", 32'(last_err), 32'b0010);
        chk("tmo_cnt",    32'(tmo_cnt_o), 1);

        // Fairness from a fresh reset: 0,1,2,3,0,1.
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        ack_dly = 0;
        for (int i = 0; i < NMST; i++)
            setm(i, 32'hFFD0_1000 + 32'(i * 16), 1'(i & 1), 4'(1 << i), 32'hA000_0000 + 32'(i));
        pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
        push(0, 1'b0); push(1, 1'b0); push(2, 1'b0); push(3, 1'b0); push(0, 1'b0); push(1, 1'b0);
        wait_done(80);

        // Filtering: master 1 outside the I/O region, master 3 inside.
        setm(1, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
        setm(3, 32'hFFD1_0000, 1'b0, 4'hF, 32'h0);
        pend[1] = 1; pend[3] = 1;
        push(3, 1'b0);
        wait_done(30);
        repeat (4) tick();
        chk("flt_gnt",  32'(gnt_o), 3);
        chk("flt_scyc", 32'(bus.s_cyc_o), 0);
        chk("flt_resp", 32'(bus.m_ack_o | bus.m_err_o), 0);
        pend[1] = 0;
        drop(1);
        tick();

        // Abort: master 0 drops cyc while in BUS with no device ack.
        auto_en = 1'b0;
        ack_dly = -1;
        setm(0, 32'hFFD0_0010, 1'b0, 4'hF, 32'h0);
        raise(0);
        tick();
        chk("abt_scyc_hi", 32'(bus.s_cyc_o), 1);
        chk("abt_gnt",     32'(gnt_o), 0);
        drop(0);
        tick();
        chk("abt_scyc_lo", 32'(bus.s_cyc_o), 0);
        chk("abt_resp",    32'(bus.m_ack_o | bus.m_err_o), 0);
        tick();
        chk("abt_tmo",     32'(tmo_cnt_o), 0);
        auto_en = 1'b1;
        ack_dly = 0;
        setm(1, 32'hFFD0_0020, 1'b0, 4'hF, 32'h0);
        pend[1] = 1;
        push(1, 1'b0);
        wait_done(20);

        // Reset while master 3 sits in BUS; next grant must go to master 0.
        ack_dly = -1;
        setm(3, 32'hFFD0_0300, 1'b1, 4'hC, 32'h5555_AAAA);
        pend[3] = 1;
        for (int n = 0; n < 10 && !bus.s_cyc_o; n++) tick();
        chk("mrst_pre_bus", 32'(bus.s_cyc_o), 1);
        rst_i = 1'b1;
        pend[3] = 0;
        drop(3);
        tick();
        chk("mrst_scyc",  32'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 0);
        chk("mrst_ssel",  32'(bus.s_sel_o), 0);
        chk("mrst_sadr",  bus.s_adr_o, 0);
        chk("mrst_sdat",  bus.s_dat_o, 0);
        chk("mrst_resp",  32'(bus.m_ack_o | bus.m_err_o), 0);
        chk("mrst_mdat",  bus.m_dat_o, 0);
        chk("mrst_gnt",   32'(gnt_o), 0);
        rst_i = 1'b0;
        ack_dly = 0;
        setm(0, 32'hFFD0_0400, 1'b0, 4'hF, 32'h0);
        setm(2, 32'hFFD0_0500, 1'b0, 4'hF, 32'h0);
        pend[0] = 1; pend[2] = 1;
        push(0, 1'b0); push(2, 1'b0);
        wait_done(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
